// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: hazard FSM states and architectural register constants.
package riscv_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ABANDON  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc, sticks at all-ones.
// Latency 1 cycle (registered count); no backpressure.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, branch flushes, load-use bubbles, perf counters.
// Controls are combinational (Mealy) from state + inputs; counters/flag update one cycle later.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_redirect,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    hz_state_t  r_state;
    hz_state_t  w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic       r_mem_timeout;
    logic       w_timeout_set;
    logic       w_mem_hold;
    logic       w_load_use;
    logic       w_bubble;

    assign w_mem_hold = dmem_req && !dmem_ready;
    assign w_load_use = ex_memread && (ex_rd != REG_X0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pc_redirect   = 1'b0;
        w_bubble      = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_set = 1'b0;

        // Once abandoned, the pending access no longer holds the pipeline.
        if (!rst) begin
            if (w_mem_hold && (r_state != ST_ABANDON)) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                pc_redirect  = 1'b1;
            end else if (w_load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_flush  = 1'b1;
                w_bubble     = 1'b1;
            end
        end

        case (r_state)
            ST_RUN: begin
                if (w_mem_hold) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_hold) begin
                    if (r_wait_cnt == TIMEOUT_CNT) begin
                        w_state_nxt   = ST_ABANDON;
                        w_timeout_set = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_ABANDON: begin
                if (!dmem_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ex_mem_stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble),
        .count (bubble_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences, random run vs. reference model.
module tb_hazard_ctrl;

    localparam int T = 4;
    localparam logic [6:0] NONE   = 7'b0000000;
    localparam logic [6:0] STALL4 = 7'b1111000;
    localparam logic [6:0] FLUSH  = 7'b0000111;
    localparam logic [6:0] BUBBLE = 7'b1100010;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken, dmem_req, dmem_ready;

    logic        a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_red, a_to;
    logic [15:0] a_stall, a_bubble, a_flush;
    logic        b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_red, b_to;
    logic [1:0]  b_stall, b_bubble, b_flush;
    logic [6:0]  a_ctrl, b_ctrl;

    assign a_ctrl = {a_pcs, a_ifs, a_ids, a_exs, a_iff, a_idf, a_red};
    assign b_ctrl = {b_pcs, b_ifs, b_ids, b_exs, b_iff, b_idf, b_red};

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(a_pcs), .if_id_stall(a_ifs), .id_ex_stall(a_ids), .ex_mem_stall(a_exs),
        .if_id_flush(a_iff), .id_ex_flush(a_idf), .pc_redirect(a_red),
        .mem_timeout(a_to), .stall_cnt(a_stall), .bubble_cnt(a_bubble), .flush_cnt(a_flush)
    );

    hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(b_pcs), .if_id_stall(b_ifs), .id_ex_stall(b_ids), .ex_mem_stall(b_exs),
        .if_id_flush(b_iff), .id_ex_flush(b_idf), .pc_redirect(b_red),
        .mem_timeout(b_to), .stall_cnt(b_stall), .bubble_cnt(b_bubble), .flush_cnt(b_flush)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: hold cycles seen in the current memory episode, abandon flag, event tallies.
    int m_k, m_stall, m_bubble, m_flush;
    bit m_aband, m_to;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       br, req, rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit f_load_use();
        return ex_memread && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [6:0] f_ctrl();
        if (rst) return NONE;
        if (dmem_req && !dmem_ready && !m_aband) return STALL4;
        if (ex_branch_taken) return FLUSH;
        if (f_load_use()) return BUBBLE;
        return NONE;
    endfunction

    // A hold episode stalls for T+2 cycles (entry cycle, counter 0..T-1, compare cycle) before abandoning.
    task automatic model_edge();
        logic [6:0] c;
        c = f_ctrl();
        if (rst) begin
            m_k = 0; m_aband = 0; m_to = 0;
            m_stall = 0; m_bubble = 0; m_flush = 0;
        end else begin
            if (c[3]) m_stall++;
            if (c == BUBBLE) m_bubble++;
            if (c[0]) m_flush++;
            if (m_aband) begin
                if (!dmem_req) m_aband = 0;
            end else if (dmem_req && !dmem_ready) begin
                m_k++;
                if (m_k == T + 2) begin
                    m_aband = 1; m_to = 1; m_k = 0;
                end
            end else begin
                m_k = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic mr, input logic [4:0] rd,
                          input logic br, input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_memread = mr; ex_rd = rd; ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1, 1, 1, 1, 1, 1, 1, 1, 0);
        chk("rst_ctrl_zero", a_ctrl, NONE);
        step();
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_k = 0; m_aband = 0; m_to = 0; m_stall = 0; m_bubble = 0; m_flush = 0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("reset_ctrl", a_ctrl, NONE);
        chk("reset_timeout", a_to, 0);
        chk("reset_stall_cnt", a_stall, 0);
        chk("reset_bubble_cnt", a_bubble, 0);
        chk("reset_flush_cnt", a_flush, 0);

        // Decode table (holds never run long enough to time out)
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE};
        vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, BUBBLE};
        vecs[2]  = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, BUBBLE};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, NONE};
        vecs[4]  = '{5'd1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, NONE};
        vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, NONE};
        vecs[6]  = '{5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, NONE};
        vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, FLUSH};
        vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, BUBBLE};
        vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, STALL4};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NONE};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, STALL4};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, FLUSH};
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].mr,
                   vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
            chk($sformatf("vec%0d_ctrl", i), a_ctrl, vecs[i].exp);
            step();
        end

        // Load-use bubble counted once
        do_reset();
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        chk("lu_ctrl", a_ctrl, BUBBLE);
        step();
        idle();
        chk("lu_bubble_cnt", a_bubble, 1);

        // Branch wins over load-use
        do_reset();
        set_in(5, 0, 1, 0, 1, 5, 1, 0, 0);
        chk("br_lu_ctrl", a_ctrl, FLUSH);
        step();
        idle();
        chk("br_lu_flush_cnt", a_flush, 1);
        chk("br_lu_bubble_cnt", a_bubble, 0);

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("wait%0d_ctrl", i), a_ctrl, STALL4);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("wait_ready_ctrl", a_ctrl, NONE);
        step();
        idle();
        chk("wait_stall_cnt", a_stall, 3);
        chk("wait_timeout", a_to, 0);

        // Timeout, abandon, recovery, sticky flag
        do_reset();
        for (int i = 0; i < T + 2; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("to_hold%0d_ctrl", i), a_ctrl, STALL4);
            chk($sformatf("to_hold%0d_flag", i), a_to, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("aband_ctrl", a_ctrl, NONE);
        chk("aband_flag", a_to, 1);
        step();
        set_in(5, 0, 1, 0, 1, 5, 0, 1, 0);
        chk("aband_lu_ctrl", a_ctrl, BUBBLE);
        step();
        idle();
        chk("aband_exit_ctrl", a_ctrl, NONE);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rerun_ctrl", a_ctrl, STALL4);
        chk("rerun_flag", a_to, 1);
        step();
        idle();
        chk("to_stall_cnt", a_stall, T + 3);
        step();
        chk("sticky_flag", a_to, 1);
        do_reset();
        chk("flag_cleared", a_to, 0);

        // Reset in the middle of a wait
        do_reset();
        for (int i = 0; i < T + 1; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step();
        end
        do_reset();
        for (int i = 0; i < T + 1; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("mid_rst%0d_ctrl", i), a_ctrl, STALL4);
            step();
        end
        chk("mid_rst_flag", a_to, 0);

        // Saturation on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
            step();
        end
        idle();
        chk("sat_bubble_cnt", b_bubble, 3);
        chk("wide_bubble_cnt", a_bubble, 5);
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        step();
        idle();
        chk("sat_bubble_held", b_bubble, 3);

        // Random run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0));
            chk("rnd_ctrl", a_ctrl, f_ctrl());
            chk("rnd_ctrl_b", b_ctrl, f_ctrl());
            chk("rnd_timeout", a_to, m_to);
            chk("rnd_stall_cnt", a_stall, sat(m_stall, 16));
            chk("rnd_bubble_cnt", a_bubble, sat(m_bubble, 16));
            chk("rnd_flush_cnt", a_flush, sat(m_flush, 16));
            chk("rnd_stall_cnt_b", b_stall, sat(m_stall, 2));
            chk("rnd_bubble_cnt_b", b_bubble, sat(m_bubble, 2));
            chk("rnd_flush_cnt_b", b_flush, sat(m_flush, 2));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
